// File: rtl/tkm_logic_pkg.sv
// Purpose : shared op codes, FSM state type and uio pin indices for the TKM logic unit.
// Latency : n/a (constants only).
// Backpressure: n/a.
package tkm_logic_pkg;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NAND = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_ADD  = 3'b110;
   localparam logic [2:0] OP_ACC  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // uio_in control bits
   localparam int UIO_OP_LSB = 0;
   localparam int UIO_LOAD_A = 3;
   localparam int UIO_LOAD_B = 4;
   localparam int UIO_GO     = 5;
   // uio_out status bits
   localparam int UIO_VALID  = 6;
   localparam int UIO_CARRY  = 7;

   localparam logic [7:0] UIO_OE_MASK = 8'hC0;

endpackage

// File: rtl/tkm_logic_if.sv
// Purpose : pin bundle of the TKM logic unit (ena, ui/uio in, uo/uio out, uio_oe).
// Latency : n/a (wires only).
// Backpressure: none; strobes are edge-triggered pins, no handshake.
interface tkm_logic_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   // master drives the pins into the unit, slave is the unit itself
   modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
   modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tkm_sync_edge.sv
// Purpose : synchronise one asynchronous strobe pin and emit a 1-cycle pulse per rising edge.
// Latency : pulse appears SYNC_STAGES clock edges after the pin rises.
// Backpressure: none; a pin held high produces a single pulse.
// Ports   : clk, rst_n (async active-low), d (raw pin), pulse (1-cycle output).
module tkm_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Edge flop clears on reset, so a pin held high through release still yields one pulse.
   assign pulse = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/tt_um_tkm_logic_unit.sv
// Purpose : strobe-driven A/B logic/ADD/ACC unit; ui_in operand, uio_in control, uo_out result.
// Latency : result and valid visible 2 cycles after the internal go pulse.
// Backpressure: none; go during EXEC is dropped, ena=0 masks strobes and freezes all state.
// Ports   : clk, rst_n, ena, ui_in[7:0], uio_in[7:0] in; uo_out, uio_out {carry,valid}, uio_oe out.
module tt_um_tkm_logic_unit
   import tkm_logic_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic             ld_a_raw, ld_b_raw, go_raw;
   logic             ld_a, ld_b, go;
   state_t           state_q, state_d;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic             carry_q;
   logic             valid, exec_fire, op_capture;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             unused_pins;

   tkm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ld_a (
      .clk(clk), .rst_n(rst_n), .d(uio_in[UIO_LOAD_A]), .pulse(ld_a_raw));
   tkm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ld_b (
      .clk(clk), .rst_n(rst_n), .d(uio_in[UIO_LOAD_B]), .pulse(ld_b_raw));
   tkm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_go (
      .clk(clk), .rst_n(rst_n), .d(uio_in[UIO_GO]), .pulse(go_raw));

   // Synchronisers keep running while disabled so no stale edge fires on re-enable.
   assign ld_a = ld_a_raw & ena;
   assign ld_b = ld_b_raw & ena;
   assign go   = go_raw   & ena;

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state; go beats the load-triggered return to IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (go) state_d = ST_EXEC;
         ST_EXEC: if (ena) state_d = ST_DONE;
         ST_DONE: begin
            if (go)               state_d = ST_EXEC;
            else if (ld_a | ld_b) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      valid      = (state_q == ST_DONE);
      exec_fire  = (state_q == ST_EXEC) && ena;
      op_capture = go && (state_q != ST_EXEC);
   end

   // EXEC sees A/B as registered, so go-cycle loads count and EXEC-cycle loads wait.
   always_comb begin
      sum       = {1'b0, a_q} + {1'b0, b_q};
      alu_carry = 1'b0;
      unique case (op_q)
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_NAND: alu_res = ~(a_q & b_q);
         OP_NOR:  alu_res = ~(a_q | b_q);
         OP_XNOR: alu_res = ~(a_q ^ b_q);
         OP_ADD: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
         end
         default: alu_res = res_q ^ a_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_AND;
         res_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         if (ld_a)       a_q  <= ui_in[WIDTH-1:0];
         if (ld_b)       b_q  <= ui_in[WIDTH-1:0];
         if (op_capture) op_q <= uio_in[UIO_OP_LSB +: 3];
         if (exec_fire) begin
            res_q   <= alu_res;
            carry_q <= alu_carry;
         end
      end
   end

   always_comb begin
      uo_out               = '0;
      uo_out[WIDTH-1:0]    = res_q;
      uio_out              = '0;
      uio_out[UIO_VALID]   = valid;
      uio_out[UIO_CARRY]   = carry_q;
      uio_oe               = UIO_OE_MASK;
   end

   // Upper operand bits and uio_in[7:6] are intentionally ignored.
   assign unused_pins = &{1'b0, ui_in, uio_in[7:6]};

endmodule

// File: tb/tb_tt_um_tkm_logic_unit.sv
// Purpose : self-checking bench driving a WIDTH=8 and a WIDTH=4 unit with identical pins.
// Latency : expects valid/result SYNC_STAGES+2 edges after a go pin rise.
// Backpressure: n/a.
module tb_tt_um_tkm_logic_unit;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   tkm_logic_if bus8();
   tkm_logic_if bus4();

   assign bus4.ena    = bus8.ena;
   assign bus4.ui_in  = bus8.ui_in;
   assign bus4.uio_in = bus8.uio_in;

   tt_um_tkm_logic_unit #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .ena(bus8.ena), .ui_in(bus8.ui_in), .uio_in(bus8.uio_in),
      .uo_out(bus8.uo_out), .uio_out(bus8.uio_out), .uio_oe(bus8.uio_oe));

   tt_um_tkm_logic_unit #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .ena(bus4.ena), .ui_in(bus4.ui_in), .uio_in(bus4.uio_in),
      .uo_out(bus4.uo_out), .uio_out(bus4.uio_out), .uio_oe(bus4.uio_oe));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: index 0 is the 8-bit unit, index 1 the 4-bit unit.
   int W[2] = '{8, 4};
   int ma[2], mb[2], mres[2];
   bit mc[2], mv[2];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_w8_uo"},  bus8.uo_out,  8'(mres[0]));
      chk({tag, "_w8_uio"}, bus8.uio_out, {mc[0], mv[0], 6'b0});
      chk({tag, "_w8_oe"},  bus8.uio_oe,  8'hC0);
      chk({tag, "_w4_uo"},  bus4.uo_out,  8'(mres[1]));
      chk({tag, "_w4_uio"}, bus4.uio_out, {mc[1], mv[1], 6'b0});
      chk({tag, "_w4_oe"},  bus4.uio_oe,  8'hC0);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         ma[k] = 0; mb[k] = 0; mres[k] = 0; mc[k] = 0; mv[k] = 0;
      end
   endtask

   task automatic model_op(input int op, input bit la, input bit lb, input int d);
      for (int k = 0; k < 2; k++) begin
         int m, s;
         m = (1 << W[k]) - 1;
         if (la) ma[k] = d & m;
         if (lb) mb[k] = d & m;
         mc[k] = 0;
         case (op)
            0: mres[k] = ma[k] & mb[k];
            1: mres[k] = ma[k] | mb[k];
            2: mres[k] = ma[k] ^ mb[k];
            3: mres[k] = ~(ma[k] & mb[k]) & m;
            4: mres[k] = ~(ma[k] | mb[k]) & m;
            5: mres[k] = ~(ma[k] ^ mb[k]) & m;
            6: begin
               s       = ma[k] + mb[k];
               mres[k] = s & m;
               mc[k]   = bit'((s >> W[k]) & 1);
            end
            default: mres[k] = mres[k] ^ ma[k];
         endcase
         mv[k] = 1;
      end
   endtask

   task automatic do_load(input bit la, input bit lb, input logic [7:0] d);
      @(negedge clk);
      bus8.ui_in  = d;
      bus8.uio_in = {3'b000, lb, la, 3'b000};
      repeat (4) @(negedge clk);
      bus8.uio_in = 8'h00;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         if (la) ma[k] = d & ((1 << W[k]) - 1);
         if (lb) mb[k] = d & ((1 << W[k]) - 1);
         mv[k] = 0;
      end
      check_all("load");
   endtask

   // Pin rise at N0; pulse cycle P2..P3; EXEC P3..P4; DONE from P4.
   task automatic do_op(input string tag, input int op, input bit la, input bit lb,
                        input logic [7:0] d);
      @(negedge clk);
      bus8.ui_in  = d;
      bus8.uio_in = {2'b00, 1'b1, lb, la, 3'(op)};
      repeat (3) @(negedge clk);
      chk({tag, "_exec_w8_valid"}, {7'b0, bus8.uio_out[6]}, 8'h00);
      chk({tag, "_exec_w4_valid"}, {7'b0, bus4.uio_out[6]}, 8'h00);
      @(negedge clk);
      model_op(op, la, lb, d);
      check_all(tag);
      bus8.uio_in = 8'h00;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst_n       = 1'b0;
      bus8.ena    = 1'b1;
      bus8.ui_in  = 8'h00;
      bus8.uio_in = 8'h00;
      model_reset();
      #2;
      check_all("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_all("post_reset");

      // ACC twice from a cleared result
      do_load(1'b1, 1'b0, 8'h3C);
      do_op("acc1", 7, 1'b0, 1'b0, 8'h00);
      do_op("acc2", 7, 1'b0, 1'b0, 8'h00);

      // XOR A5 ^ 0F
      do_load(1'b1, 1'b0, 8'hA5);
      do_load(1'b0, 1'b1, 8'h0F);
      do_op("xor", 2, 1'b0, 1'b0, 8'h00);

      // ADD with carry out, then AND of the same operands
      do_load(1'b1, 1'b0, 8'hFF);
      do_load(1'b0, 1'b1, 8'h01);
      do_op("add_carry", 6, 1'b0, 1'b0, 8'h00);
      do_op("and", 0, 1'b0, 1'b0, 8'h00);

      // NAND of all-ones, loads riding in the go cycle from DONE
      do_op("nand_ff", 3, 1'b1, 1'b1, 8'hFF);

      // Disabled unit ignores every strobe
      @(negedge clk);
      bus8.ena    = 1'b0;
      bus8.ui_in  = 8'h5A;
      bus8.uio_in = 8'h3A;
      repeat (4) @(negedge clk);
      bus8.uio_in = 8'h00;
      repeat (4) @(negedge clk);
      check_all("ena_off");
      bus8.ena = 1'b1;
      @(negedge clk);
      check_all("ena_back");

      // Randomised operations, some with loads in the go cycle
      for (int i = 0; i < 30; i++) begin
         int          op;
         bit          la, lb;
         logic [7:0]  d;
         op = int'($urandom_range(0, 7));
         la = 1'($urandom);
         lb = 1'($urandom);
         d  = 8'($urandom);
         if ($urandom_range(0, 3) == 0) do_load(1'($urandom), 1'b1, 8'($urandom));
         do_op("rand", op, la, lb, d);
      end

      // Ensure a non-zero result before aborting an operation with reset
      do_op("pre_abort", 3, 1'b1, 1'b1, 8'h00);

      // Reset during EXEC with go/loads held high through release: one ACC only
      @(negedge clk);
      bus8.ui_in  = 8'h96;
      bus8.uio_in = {2'b00, 1'b1, 1'b1, 1'b1, 3'(7)};
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      model_reset();
      #1 check_all("abort_async");
      repeat (2) @(negedge clk);
      check_all("abort_held");
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      model_op(7, 1'b1, 1'b1, 8'h96);
      check_all("release_one_op");
      bus8.uio_in = 8'h00;
      repeat (6) @(negedge clk);
      check_all("release_settled");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tt_um_tkm_logic_unit.md
TT_UM_TKM_LOGIC_UNIT -- requirements
Module: tt_um_tkm_logic_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width; legal range 1..8.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser flops per strobe; legal range 2..3.
REQ-003 SHALL have port clk  input  1  the single clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  design enable; when low, strobe pulses are ignored and state is held.
REQ-006 SHALL have port ui_in  input  8  operand data; bits [WIDTH-1:0] are used.
REQ-007 SHALL have port uio_in  input  8  control: [2:0] op, [3] load_a, [4] load_b, [5] go, [7:6] unused.
REQ-008 SHALL have port uo_out  output  8  result, zero-extended above WIDTH.
REQ-009 SHALL have port uio_out  output  8  [6] valid, [7] carry, [5:0] tied 0.
REQ-010 SHALL have port uio_oe  output  8  constant 8'hC0.

Function
REQ-011 Each strobe (load_a, load_b, go) SHALL pass through a SYNC_STAGES-flop synchroniser and a rising-edge detector, producing a one-cycle internal pulse per pin rising edge.
REQ-012 A load_a pulse SHALL write ui_in[WIDTH-1:0] into register A at the end of the pulse cycle; load_b likewise into B. Data must be held stable for SYNC_STAGES+2 cycles after the strobe rises.
REQ-013 FSM states SHALL be IDLE, EXEC and DONE: IDLE/DONE --go pulse--> EXEC; EXEC --> DONE (unconditional); DONE --load pulse without go--> IDLE.
REQ-014 Op SHALL be sampled from uio_in[2:0] in the go pulse cycle.
REQ-015 Op codes SHALL be: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 ADD (A+B mod 2^WIDTH), 111 ACC (result <= result XOR A).
REQ-016 EXEC SHALL compute from the A/B values held during the EXEC cycle. A load in the go cycle SHALL be included. A load in the EXEC cycle SHALL apply only to the next operation.
REQ-017 Result and carry SHALL register at the end of EXEC; with a go pulse in cycle t, valid=1 and the new result SHALL be visible at t+2.
REQ-018 Carry SHALL be bit WIDTH of A+B for ADD, and 0 for every other op.
REQ-019 Valid SHALL be 1 only in DONE. Result and carry SHALL hold their values through IDLE until the next EXEC.
REQ-020 A go pulse during EXEC SHALL be ignored. A go pulse in DONE SHALL start a new operation, with valid dropping during EXEC.
REQ-021 Simultaneous load and go in DONE SHALL perform the load and enter EXEC (go wins over return-to-IDLE).
REQ-022 uo_out[7:WIDTH] SHALL be 0 for WIDTH<8.

Reset
REQ-023 While rst_n=0, all of the following SHALL be 0 immediately and asynchronously: A, B, result, carry, valid, synchroniser and edge flops; the FSM SHALL be in IDLE.
REQ-024 A strobe held high across reset release SHALL produce exactly one pulse after synchronisation.
REQ-025 Reset asserted mid-EXEC SHALL abort the operation; no result update SHALL occur after release.

Structure
REQ-026 Package tkm_logic_pkg SHALL hold the op-code constants, the FSM state type and the uio bit-index constants.
REQ-027 Sub-module tkm_sync_edge (parameter SYNC_STAGES; in: clk, rst_n, d; out: pulse) SHALL be instantiated once per strobe.

Verification
REQ-028 Bench SHALL cover (WIDTH=8): A=0xA5, B=0x0F, op XOR -> uo_out=0xAA, valid=1, carry=0, valid asserted exactly 2 cycles after the internal go pulse.
REQ-029 Bench SHALL cover: A=0xFF, B=0x01, op ADD -> uo_out=0x00, carry=1; then op AND -> uo_out=0x01, carry=0.
REQ-030 Bench SHALL cover: after reset, A=0x3C, op ACC, two go strobes -> uo_out=0x3C, then 0x00.
REQ-031 Bench SHALL cover (WIDTH=4): A=0xF, B=0x1, ADD -> uo_out=0x00, carry=1; NAND of 0xF,0xF -> uo_out=0x00; uo_out[7:4]=0 throughout.
REQ-032 Bench SHALL cover: rst_n low during EXEC -> uo_out=0 and valid=0 without a clock edge; go held high through release -> exactly one operation.
REQ-033 Bench SHALL cover: ena=0 with go toggled -> no state change; uio_oe=8'hC0 in all tests.
